dg0045_nd_scanner: RTL and testbench

Downstream display stage for the DG0045 4-bit core. It watches the core's active-low digit-latch outputs nL[3:0] and its active-low shift strobe ND, which pulses during the SHD0, SHD1, RNP and SNP instructions. Each valid ND pulse pushes the nibble ~nL into a digit shift buffer. The block time-multiplexes that buffer onto a common-cathode 7-segment display with one-hot, active-low digit selects.

---
 rtl/dg0045_disp_pkg.sv | 19 +
 rtl/dg0045_hex7.sv | 11 +
 rtl/dg0045_nd_scanner.sv | 105 ++++++++++
 tb/tb_dg0045_nd_scanner.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dg0045_disp_pkg.sv
// Shared constants for the DG0045 ND-strobe capture and digit scanner.
// Segment codes are {g,f,e,d,c,b,a}, active-high.
package dg0045_disp_pkg;

    localparam int DIGITS_DEF    = 6;
    localparam int SCAN_DIV_DEF  = 1024;
    localparam int BLANK_CYC_DEF = 16;
    localparam int MIN_LOW_DEF   = 2;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [6:0] HEX7 [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/dg0045_hex7.sv
// Nibble to 7-segment decoder covering all sixteen hex codes.
module dg0045_hex7
    import dg0045_disp_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = HEX7[nib];

endmodule

// File: rtl/dg0045_nd_scanner.sv
// Captures nibbles on qualified ND strobes and scans them onto a
// multiplexed common-cathode 7-segment display.
module dg0045_nd_scanner
    import dg0045_disp_pkg::*;
#(
    parameter int DIGITS    = DIGITS_DEF,
    parameter int SCAN_DIV  = SCAN_DIV_DEF,
    parameter int BLANK_CYC = BLANK_CYC_DEF,
    parameter int MIN_LOW   = MIN_LOW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              nd_n,
    input  logic [3:0]        nl_n,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] dig_n,
    output logic              cap_pulse
);

    localparam int LW = $clog2(MIN_LOW + 1);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(DIGITS);

    logic                   nd_s1, nd_s, nd_q;
    logic [3:0]             nl_s1, nl_s;
    logic [LW-1:0]          lowcnt;
    logic [DIGITS-1:0][3:0] digit_buf;
    logic [DW-1:0]          divcnt;
    logic [IW-1:0]          idx;
    logic [6:0]             cur_seg;
    logic [DIGITS-1:0]      sel;
    logic                   capture;
    logic                   blank;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nd_s1 <= 1'b1;
            nd_s  <= 1'b1;
            nd_q  <= 1'b1;
            nl_s1 <= '1;
            nl_s  <= '1;
        end else begin
            nd_s1 <= nd_n;
            nd_s  <= nd_s1;
            nd_q  <= nd_s;
            nl_s1 <= nl_n;
            nl_s  <= nl_s1;
        end
    end

    // Rising edge only: nL is settled at the end of the strobe.
    assign capture = nd_s & ~nd_q & (lowcnt == LW'(MIN_LOW));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lowcnt    <= '0;
            digit_buf <= '0;
            cap_pulse <= 1'b0;
        end else begin
            if (nd_s) begin
                lowcnt <= '0;
            end else if (lowcnt != LW'(MIN_LOW)) begin
                lowcnt <= lowcnt + 1'b1;
            end
            cap_pulse <= capture;
            if (capture) begin
                digit_buf <= {digit_buf[DIGITS-2:0], ~nl_s};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divcnt <= '0;
            idx    <= '0;
        end else if (divcnt == DW'(SCAN_DIV - 1)) begin
            divcnt <= '0;
            idx    <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            divcnt <= divcnt + 1'b1;
        end
    end

    dg0045_hex7 u_hex7 (
        .nib (digit_buf[idx]),
        .seg (cur_seg)
    );

    assign blank = divcnt < DW'(BLANK_CYC);
    assign sel   = {{(DIGITS-1){1'b0}}, 1'b1} << idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg   <= SEG_BLANK;
            dig_n <= '1;
        end else if (blank) begin
            seg   <= SEG_BLANK;
            dig_n <= '1;
        end else begin
            seg   <= cur_seg;
            dig_n <= ~sel;
        end
    end

endmodule

// File: tb/tb_dg0045_nd_scanner.sv
// Randomized bench for dg0045_nd_scanner with a queue-style buffer model
// and a frame-position model of the multiplexed display.
module tb_dg0045_nd_scanner;

    localparam int DIGITS    = 6;
    localparam int SCAN_DIV  = 32;
    localparam int BLANK_CYC = 4;
    localparam int MIN_LOW   = 2;
    localparam int FRAME     = DIGITS * SCAN_DIV;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              nd_n = 1'b1;
    logic [3:0]        nl_n = 4'hF;
    logic [6:0]        seg;
    logic [DIGITS-1:0] dig_n;
    logic              cap_pulse;

    int checks   = 0;
    int failures = 0;
    int cap_cnt  = 0;
    int disp_err;

    logic [3:0] exp_buf [DIGITS];
    logic [6:0] obs_seg [DIGITS];
    logic       seen    [DIGITS];

    dg0045_nd_scanner #(
        .DIGITS    (DIGITS),
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC),
        .MIN_LOW   (MIN_LOW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .nd_n      (nd_n),
        .nl_n      (nl_n),
        .seg       (seg),
        .dig_n     (dig_n),
        .cap_pulse (cap_pulse)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cap_pulse === 1'b1) cap_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] hex_ref(input logic [3:0] v);
        logic [6:0] r;
        r = 7'h00;
        case (v)
            4'h0: r = 7'h3F;  4'h1: r = 7'h06;
            4'h2: r = 7'h5B;  4'h3: r = 7'h4F;
            4'h4: r = 7'h66;  4'h5: r = 7'h6D;
            4'h6: r = 7'h7D;  4'h7: r = 7'h07;
            4'h8: r = 7'h7F;  4'h9: r = 7'h6F;
            4'hA: r = 7'h77;  4'hB: r = 7'h7C;
            4'hC: r = 7'h39;  4'hD: r = 7'h5E;
            4'hE: r = 7'h79;  4'hF: r = 7'h71;
            default: r = 7'h00;
        endcase
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DIGITS; i++) exp_buf[i] = 4'h0;
    endtask

    task automatic model_push(input logic [3:0] v);
        for (int i = DIGITS - 1; i > 0; i--) exp_buf[i] = exp_buf[i-1];
        exp_buf[0] = v;
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        nd_n = 1'b1;
        nl_n = 4'hF;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    // Called at a falling edge; data is presented as ~nL.
    task automatic nd_pulse(input logic [3:0] nib, input int low,
                            input int pre, input int post);
        nl_n = ~nib;
        repeat (pre) @(negedge clk);
        nd_n = 1'b0;
        repeat (low) @(negedge clk);
        nd_n = 1'b1;
        repeat (post) @(negedge clk);
        if (low >= MIN_LOW) model_push(nib);
    endtask

    task automatic read_display();
        int zeros;
        int pos;
        disp_err = 0;
        for (int d = 0; d < DIGITS; d++) begin
            seen[d]    = 1'b0;
            obs_seg[d] = 7'h00;
        end
        repeat (FRAME + SCAN_DIV) begin
            @(posedge clk);
            #1;
            if (dig_n === '1) begin
                if (seg !== 7'h00) disp_err++;
            end else begin
                zeros = 0;
                pos   = 0;
                for (int d = 0; d < DIGITS; d++) begin
                    if (dig_n[d] === 1'b0) begin
                        zeros++;
                        pos = d;
                    end
                end
                if (zeros != 1) begin
                    disp_err++;
                end else if (seen[pos] && obs_seg[pos] !== seg) begin
                    disp_err++;
                end else begin
                    seen[pos]    = 1'b1;
                    obs_seg[pos] = seg;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        int bad;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (seg !== 7'h00) begin
            failures++;
            $display("FAIL reset_seg got=%h exp=00", seg);
        end
        checks++;
        if (dig_n !== 6'h3F) begin
            failures++;
            $display("FAIL reset_dig_n got=%h exp=3F", dig_n);
        end
        checks++;
        if (cap_pulse !== 1'b0) begin
            failures++;
            $display("FAIL reset_cap got=%b exp=0", cap_pulse);
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        bad = 0;
        for (int e = 1; e <= BLANK_CYC; e++) begin
            @(posedge clk);
            #1;
            if (dig_n !== 6'h3F || seg !== 7'h00) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL reset_blank_phase got=%0d bad exp=0", bad);
        end
        @(posedge clk);
        #1;
        checks++;
        if (seg !== 7'h3F || dig_n !== 6'h3E) begin
            failures++;
            $display("FAIL reset_first_drive got=%h/%h exp=3F/3E",
                     seg, dig_n);
        end
        @(negedge clk);
    endtask

    task automatic test_single_capture();
        int c0;
        logic [3:0] pat;
        settle();
        c0   = cap_cnt;
        nl_n = 4'hA;
        repeat (2) @(negedge clk);
        nd_n = 1'b0;
        repeat (2) @(negedge clk);
        nd_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            pat[3-i] = cap_pulse;
        end
        @(negedge clk);
        model_push(4'h5);
        checks++;
        if (pat !== 4'b0010) begin
            failures++;
            $display("FAIL single_cap_timing got=%b exp=0010", pat);
        end
        settle();
        checks++;
        if (cap_cnt - c0 != 1) begin
            failures++;
            $display("FAIL single_cap_count got=%0d exp=1", cap_cnt - c0);
        end
        read_display();
        checks++;
        if (disp_err != 0) begin
            failures++;
            $display("FAIL single_frame got=%0d errs exp=0", disp_err);
        end
        checks++;
        if (!seen[0] || obs_seg[0] !== 7'h6D) begin
            failures++;
            $display("FAIL single_digit0 got=%h exp=6D", obs_seg[0]);
        end
        for (int d = 1; d < DIGITS; d++) begin
            checks++;
            if (!seen[d] || obs_seg[d] !== hex_ref(exp_buf[d])) begin
                failures++;
                $display("FAIL single_digit%0d got=%h exp=%h",
                         d, obs_seg[d], hex_ref(exp_buf[d]));
            end
        end
    endtask

    task automatic test_overflow();
        int c0;
        do_reset();
        settle();
        c0 = cap_cnt;
        for (int v = 1; v <= 7; v++) nd_pulse(4'(v), 2, 2, 2);
        settle();
        checks++;
        if (cap_cnt - c0 != 7) begin
            failures++;
            $display("FAIL overflow_caps got=%0d exp=7", cap_cnt - c0);
        end
        read_display();
        checks++;
        if (disp_err != 0) begin
            failures++;
            $display("FAIL overflow_frame got=%0d errs exp=0", disp_err);
        end
        for (int d = 0; d < DIGITS; d++) begin
            checks++;
            if (!seen[d] || obs_seg[d] !== hex_ref(4'(7 - d))) begin
                failures++;
                $display("FAIL overflow_digit%0d got=%h exp=%h",
                         d, obs_seg[d], hex_ref(4'(7 - d)));
            end
        end
    endtask

    task automatic test_glitch();
        int c0;
        settle();
        c0 = cap_cnt;
        nd_pulse(4'h9, 1, 2, 3);
        settle();
        checks++;
        if (cap_cnt - c0 != 0) begin
            failures++;
            $display("FAIL glitch_caps got=%0d exp=0", cap_cnt - c0);
        end
        read_display();
        for (int d = 0; d < DIGITS; d++) begin
            checks++;
            if (!seen[d] || obs_seg[d] !== hex_ref(exp_buf[d])) begin
                failures++;
                $display("FAIL glitch_digit%0d got=%h exp=%h",
                         d, obs_seg[d], hex_ref(exp_buf[d]));
            end
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        settle();
        c0 = cap_cnt;
        for (int i = 0; i < 4; i++) begin
            nd_pulse(4'($urandom_range(15)), 2, 0, 2);
        end
        settle();
        checks++;
        if (cap_cnt - c0 != 4) begin
            failures++;
            $display("FAIL b2b_caps got=%0d exp=4", cap_cnt - c0);
        end
        read_display();
        for (int d = 0; d < DIGITS; d++) begin
            checks++;
            if (!seen[d] || obs_seg[d] !== hex_ref(exp_buf[d])) begin
                failures++;
                $display("FAIL b2b_digit%0d got=%h exp=%h",
                         d, obs_seg[d], hex_ref(exp_buf[d]));
            end
        end
    endtask

    task automatic test_random();
        int c0;
        int acc;
        int low;
        settle();
        c0  = cap_cnt;
        acc = 0;
        for (int i = 0; i < 14; i++) begin
            low = int'($urandom_range(4, 1));
            if (low >= MIN_LOW) acc++;
            nd_pulse(4'($urandom_range(15)), low,
                     int'($urandom_range(2, 0)),
                     int'($urandom_range(4, 2)));
        end
        settle();
        checks++;
        if (cap_cnt - c0 != acc) begin
            failures++;
            $display("FAIL random_caps got=%0d exp=%0d", cap_cnt - c0, acc);
        end
        read_display();
        checks++;
        if (disp_err != 0) begin
            failures++;
            $display("FAIL random_frame got=%0d errs exp=0", disp_err);
        end
        for (int d = 0; d < DIGITS; d++) begin
            checks++;
            if (!seen[d] || obs_seg[d] !== hex_ref(exp_buf[d])) begin
                failures++;
                $display("FAIL random_digit%0d got=%h exp=%h",
                         d, obs_seg[d], hex_ref(exp_buf[d]));
            end
        end
    endtask

    task automatic test_scan();
        logic [DIGITS-1:0] prev;
        logic [DIGITS-1:0] one;
        logic [DIGITS-1:0] exp_d;
        logic [6:0]        exp_s;
        bit                found;
        int                errs;
        int                pos;
        int                d;
        do_reset();
        for (int v = 5; v >= 0; v--) nd_pulse(4'(v), 2, 2, 2);
        settle();
        one   = 1;
        found = 0;
        prev  = dig_n;
        for (int i = 0; i < FRAME + SCAN_DIV && !found; i++) begin
            @(posedge clk);
            #1;
            if (prev === 6'h3F && dig_n === 6'h3E) found = 1;
            else prev = dig_n;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL scan_sync got=none exp=3F->3E");
        end else begin
            errs = 0;
            for (int j = 0; j < 2 * FRAME; j++) begin
                if (j > 0) begin
                    @(posedge clk);
                    #1;
                end
                pos = (BLANK_CYC + j) % SCAN_DIV;
                d   = ((BLANK_CYC + j) / SCAN_DIV) % DIGITS;
                if (pos < BLANK_CYC) begin
                    exp_d = '1;
                    exp_s = 7'h00;
                end else begin
                    exp_d = ~(one << d);
                    exp_s = hex_ref(exp_buf[d]);
                end
                if (dig_n !== exp_d || seg !== exp_s) begin
                    if (errs == 0) begin
                        $display("scan first diff j=%0d got=%h/%h exp=%h/%h",
                                 j, dig_n, seg, exp_d, exp_s);
                    end
                    errs++;
                end
            end
            checks++;
            if (errs != 0) begin
                failures++;
                $display("FAIL scan_sequence got=%0d errs exp=0", errs);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_pulse();
        int c0;
        nd_pulse(4'h9, 2, 2, 2);
        nd_pulse(4'hC, 2, 2, 2);
        settle();
        c0   = cap_cnt;
        nl_n = ~4'h3;
        repeat (2) @(negedge clk);
        nd_n = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        nd_n = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (cap_cnt - c0 != 0) begin
            failures++;
            $display("FAIL midrst_caps got=%0d exp=0", cap_cnt - c0);
        end
        read_display();
        for (int d = 0; d < DIGITS; d++) begin
            checks++;
            if (!seen[d] || obs_seg[d] !== 7'h3F) begin
                failures++;
                $display("FAIL midrst_digit%0d got=%h exp=3F",
                         d, obs_seg[d]);
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single_capture();
        test_overflow();
        test_glitch();
        test_back_to_back();
        test_random();
        test_scan();
        test_reset_mid_pulse();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
